// File: rtl/sram_axi_slave.sv
// AXI4 slave front end for a single-port 16K x 32 SRAM bank; one burst in flight at a time.
// Latency: write beat hits SRAM in its W handshake cycle, B follows WLAST by one cycle; read data two cycles after AR/RREADY.
// Backpressure: RVALID/BVALID hold with stable payload until RREADY/BREADY; WREADY only in the write data phase.
module sram_axi_slave #(
    parameter int IDS_W   = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int SRAM_AW = 14
) (
    input  logic                clk,
    input  logic                rst,
    // write address channel
    input  logic [IDS_W-1:0]    AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    // write data channel
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [STRB_W-1:0]   WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    // write response channel
    output logic [IDS_W-1:0]    BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    // read address channel
    input  logic [IDS_W-1:0]    ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    // read data channel
    output logic [IDS_W-1:0]    RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    // SRAM port
    output logic                sram_cs,
    output logic [STRB_W-1:0]   sram_we,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_DATA  = 3'd1,
        S_W_RESP  = 3'd2,
        S_R_FETCH = 3'd3,
        S_R_DATA  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDS_W-1:0]    id_q, id_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [SRAM_AW-1:0]  addr_nxt;

    // Transfer size is always a full word and upper address bits are decoded upstream.
    logic unused_inputs;
    assign unused_inputs = ^{AWSIZE, ARSIZE, AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0],
                             ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0]};

    // FIXED bursts stay on one word; INCR and WRAP both step one word, wrapping at the bank edge.
    assign addr_nxt = (burst_q == 2'b00) ? addr_q : addr_q + SRAM_AW'(1);

    // Next-state and transaction context: latch the accepted burst, advance per beat.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (AWVALID) begin
                    id_d    = AWID;
                    addr_d  = AWADDR[SRAM_AW+1:2];
                    len_d   = AWLEN;
                    burst_d = AWBURST;
                    cnt_d   = '0;
                    state_d = S_W_DATA;
                end else if (ARVALID) begin
                    id_d    = ARID;
                    addr_d  = ARADDR[SRAM_AW+1:2];
                    len_d   = ARLEN;
                    burst_d = ARBURST;
                    cnt_d   = '0;
                    state_d = S_R_FETCH;
                end
            end
            S_W_DATA: begin
                if (WVALID) begin
                    addr_d = addr_nxt;
                    if (WLAST) state_d = S_W_RESP;
                end
            end
            S_W_RESP: begin
                if (BREADY) state_d = S_IDLE;
            end
            S_R_FETCH: begin
                state_d = S_R_DATA;
            end
            S_R_DATA: begin
                if (RREADY) begin
                    if (cnt_q == len_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = addr_nxt;
                        state_d = S_R_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and context registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

    // Channel and SRAM outputs decoded from state; everything forced low while reset is held.
    always_comb begin
        AWREADY    = 1'b0;
        ARREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        BID        = '0;
        BRESP      = 2'b00;
        RVALID     = 1'b0;
        RID        = '0;
        RDATA      = '0;
        RRESP      = 2'b00;
        RLAST      = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    AWREADY = 1'b1;
                    ARREADY = ~AWVALID;
                end
                S_W_DATA: begin
                    WREADY = 1'b1;
                    if (WVALID) begin
                        sram_cs    = 1'b1;
                        sram_we    = WSTRB;
                        sram_addr  = addr_q;
                        sram_wdata = WDATA;
                    end
                end
                S_W_RESP: begin
                    BVALID = 1'b1;
                    BID    = id_q;
                end
                S_R_FETCH: begin
                    sram_cs   = 1'b1;
                    sram_addr = addr_q;
                end
                S_R_DATA: begin
                    RVALID = 1'b1;
                    RID    = id_q;
                    RDATA  = sram_rdata;
                    RLAST  = (cnt_q == len_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sram_axi_slave.md
# sram_axi_slave

AXI4 slave front end for one on-chip SRAM bank (16384 × 32-bit, 64 KB), attached to a slave port (S0 or S1) of the 2-master/2-slave interconnect. It accepts one read or write burst at a time, converts each beat into a single-cycle SRAM access, and returns R/B responses carrying the interconnect-extended ID. It is the block directly downstream of the interconnect's slave-side AR/R/AW/W/B channels.

## Interface
Parameters:
- IDS_W, 8, slave-side ID width (master ID plus interconnect master tag)
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width; STRB_W = DATA_W/8
- SRAM_AW, 14, SRAM word-address width; word index = ADDR[SRAM_AW+1:2]

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; synchronous, active-high
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  IDS_W/ADDR_W/4/3/2  write address channel
- AWVALID in 1; AWREADY out 1
- WDATA/WSTRB/WLAST  in  DATA_W/STRB_W/1  write data channel; WVALID in 1; WREADY out 1
- BID out IDS_W; BRESP out 2; BVALID out 1; BREADY in 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  IDS_W/ADDR_W/4/3/2  read address channel
- ARVALID in 1; ARREADY out 1
- RID out IDS_W; RDATA out DATA_W; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1
- sram_cs  out 1  SRAM access enable, active-high
- sram_we  out STRB_W  byte write enables; all-zero with sram_cs=1 means read
- sram_addr out SRAM_AW  word address
- sram_wdata out DATA_W; sram_rdata in DATA_W  (valid cycle after read issue; held until next access)

## Operation
- States: IDLE, W_DATA, W_RESP, R_FETCH, R_DATA. One transaction outstanding; no read/write overlap.
- IDLE: AWREADY=1; ARREADY=~AWVALID (write wins when both valid). Handshake latches ID, ADDR[SRAM_AW+1:2], LEN, BURST; beat counter cleared.
- AW handshake -> W_DATA. WREADY=1. Each WVALID beat: sram_cs=1, sram_we=WSTRB, sram_addr=current, sram_wdata=WDATA same cycle; address advances. WVALID&WLAST -> W_RESP.
- W_RESP: BVALID=1, BID=latched ID, BRESP=2'b00. BREADY -> IDLE.
- AR handshake -> R_FETCH. R_FETCH (1 cycle): sram_cs=1, sram_we=0, sram_addr=current -> R_DATA.
- R_DATA: RVALID=1, RDATA=sram_rdata, RID=latched ID, RRESP=2'b00, RLAST=(beat counter==LEN). No SRAM access. RREADY&~RLAST: counter+1, address advance -> R_FETCH; RREADY&RLAST -> IDLE.
- Address advance: BURST=2'b00 (FIXED) unchanged; 2'b01 INCR and 2'b10 WRAP both +1 word; wraps modulo 2^SRAM_AW. AWSIZE/ARSIZE ignored (full-word bus). ADDR bits above SRAM_AW+1 ignored (decoded upstream).
- Write burst ends on WLAST only; write beat count is not checked against AWLEN.
- SRAM outputs outside an access: sram_cs=0, sram_we=0; sram_addr/sram_wdata don't-care.

## Timing
- rst=1: state IDLE, all outputs 0 (AWREADY/ARREADY gated low); first cycle after rst deasserts AWREADY=1.
- Write: AW handshake cycle t; WREADY=1 from t+1; SRAM write same cycle as W handshake; BVALID the cycle after the WLAST beat; AWREADY returns cycle after B handshake.
- Read: AR handshake t; sram read at t+1; RVALID at t+2. Each further beat: RREADY at k -> fetch k+1 -> RVALID k+2 (2 cycles/beat min).
- RVALID/BVALID, once high, hold with stable payload until handshake.
- AWVALID and ARVALID both high in IDLE: AW accepted; AR waits until return to IDLE.
- rst mid-burst: abort immediately, no further SRAM access, IDLE next cycle; partial writes stay in SRAM.

## Test plan
- Reset: hold rst 3 cycles with AWVALID=ARVALID=1 -> all outputs 0; AWREADY=1 the cycle after release.
- Single write AWADDR=0x0000_0010, AWID=0x25, WDATA=0xDEADBEEF, WSTRB=4'b0101 -> sram_addr=4, sram_we=4'b0101; BVALID next cycle, BID=0x25, BRESP=0.
- INCR read ARLEN=3 at 0x0000_0100, ARID=0x12, RREADY stalled 3 cycles on beat 1 -> sram_addr 64,65,66,67; RDATA stable during stall; RLAST only on beat 3; RID=0x12.
- Simultaneous AWVALID/ARVALID in IDLE -> AWREADY=1, ARREADY=0; after B handshake, AR accepted next cycle.
- Wrap-around: INCR write AWLEN=1 at 0x0000_FFFC -> sram_addr 16383 then 0; FIXED read ARLEN=2 at 0x0000_0008 -> three fetches at sram_addr 2.
- rst asserted between W beats of a 4-beat write -> no sram_cs after reset edge; IDLE, no BVALID; next write completes normally.
